// File: rtl/sseg_pkg.sv
// Shared segment type, active-low {g,f,e,d,c,b,a} encodings and hex decode
// for the seven-segment scan controller.
package sseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF   = 7'h7F;
  localparam seg_t SEG_HEX_0 = 7'b1000000;
  localparam seg_t SEG_HEX_1 = 7'b1111001;
  localparam seg_t SEG_HEX_2 = 7'b0100100;
  localparam seg_t SEG_HEX_3 = 7'b0110000;
  localparam seg_t SEG_HEX_4 = 7'b0011001;
  localparam seg_t SEG_HEX_5 = 7'b0010010;
  localparam seg_t SEG_HEX_6 = 7'b0000010;
  localparam seg_t SEG_HEX_7 = 7'b1111000;
  localparam seg_t SEG_HEX_8 = 7'b0000000;
  localparam seg_t SEG_HEX_9 = 7'b0010000;
  localparam seg_t SEG_HEX_A = 7'b0001000;
  localparam seg_t SEG_HEX_B = 7'b0000011;
  localparam seg_t SEG_HEX_C = 7'b1000110;
  localparam seg_t SEG_HEX_D = 7'b0100001;
  localparam seg_t SEG_HEX_E = 7'b0000110;
  localparam seg_t SEG_HEX_F = 7'b0001110;

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0:    hex_to_seg = SEG_HEX_0;
      4'h1:    hex_to_seg = SEG_HEX_1;
      4'h2:    hex_to_seg = SEG_HEX_2;
      4'h3:    hex_to_seg = SEG_HEX_3;
      4'h4:    hex_to_seg = SEG_HEX_4;
      4'h5:    hex_to_seg = SEG_HEX_5;
      4'h6:    hex_to_seg = SEG_HEX_6;
      4'h7:    hex_to_seg = SEG_HEX_7;
      4'h8:    hex_to_seg = SEG_HEX_8;
      4'h9:    hex_to_seg = SEG_HEX_9;
      4'hA:    hex_to_seg = SEG_HEX_A;
      4'hB:    hex_to_seg = SEG_HEX_B;
      4'hC:    hex_to_seg = SEG_HEX_C;
      4'hD:    hex_to_seg = SEG_HEX_D;
      4'hE:    hex_to_seg = SEG_HEX_E;
      default: hex_to_seg = SEG_HEX_F;
    endcase
  endfunction

endpackage

// File: rtl/sseg_hex_decoder.sv
// Combinational hex nibble to active-low segment pattern.
module sseg_hex_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = hex_to_seg(i_nib);

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed N-digit common-anode display scanner with tear-free double buffering,
// per-digit and leading-zero blanking; SSEG_BLINK_EN adds per-digit blinking.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int N_DIG    = 4,
  parameter int PRESCALE = 50000
`ifdef SSEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 125
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [4*N_DIG-1:0] digits,
  input  logic [N_DIG-1:0]   blank_mask,
  input  logic               lzb_en,
  output logic [6:0]         sseg,
  output logic [N_DIG-1:0]   an,
  output logic               frame_done
`ifdef SSEG_BLINK_EN
  ,
  input  logic [N_DIG-1:0]   blink_mask
`endif
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(N_DIG);

  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_frame_done;
  logic [4*N_DIG-1:0] r_pend_dig;
  logic [4*N_DIG-1:0] r_act_dig;
  logic [N_DIG-1:0]   r_pend_blank;
  logic [N_DIG-1:0]   r_act_blank;
  logic               r_pend_lzb;
  logic               r_act_lzb;
  logic [6:0]         r_sseg;
  logic [N_DIG-1:0]   r_an;

  logic               w_tick;
  logic               w_last;
  logic               w_commit;
  logic [3:0]         w_nib;
  logic [6:0]         w_seg;
  logic [N_DIG-1:0]   w_lzb_blank;
  logic               w_blink_off;
  logic               w_dark;

  assign w_tick   = (r_cnt == CNT_W'(PRESCALE - 1));
  assign w_last   = (r_idx == IDX_W'(N_DIG - 1));
  assign w_commit = w_tick & w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= w_tick ? '0 : r_cnt + 1'b1;
      r_frame_done <= w_commit;
      if (w_tick) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
    end
  end

  // A load coinciding with the frame-end commit bypasses the pending stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_dig   <= '0;
      r_pend_blank <= '0;
      r_pend_lzb   <= 1'b0;
      r_act_dig    <= '0;
      r_act_blank  <= '0;
      r_act_lzb    <= 1'b0;
    end else begin
      if (load) begin
        r_pend_dig   <= digits;
        r_pend_blank <= blank_mask;
        r_pend_lzb   <= lzb_en;
      end
      if (w_commit) begin
        r_act_dig   <= load ? digits     : r_pend_dig;
        r_act_blank <= load ? blank_mask : r_pend_blank;
        r_act_lzb   <= load ? lzb_en     : r_pend_lzb;
      end
    end
  end

`ifdef SSEG_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [N_DIG-1:0] r_pend_blink;
  logic [N_DIG-1:0] r_act_blink;
  logic [BF_W-1:0]  r_frm_cnt;
  logic             r_blink_phase;

  // Frame count advances on the commit edge so the phase and the new data land together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_blink  <= '0;
      r_act_blink   <= '0;
      r_frm_cnt     <= '0;
      r_blink_phase <= 1'b1;
    end else begin
      if (load) begin
        r_pend_blink <= blink_mask;
      end
      if (w_commit) begin
        r_act_blink <= load ? blink_mask : r_pend_blink;
        if (r_frm_cnt == BF_W'(BLINK_FRAMES - 1)) begin
          r_frm_cnt     <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frm_cnt <= r_frm_cnt + 1'b1;
        end
      end
    end
  end

  assign w_blink_off = ~r_blink_phase & r_act_blink[r_idx];
`else
  assign w_blink_off = 1'b0;
`endif

  genvar g;
  for (g = 0; g < N_DIG; g++) begin : g_lzb
    if (g == 0) begin : g_d0
      assign w_lzb_blank[g] = 1'b0;
    end else begin : g_dn
      assign w_lzb_blank[g] = r_act_lzb & ~|r_act_dig[4*N_DIG-1:4*g];
    end
  end

  assign w_nib  = r_act_dig[{r_idx, 2'b00} +: 4];
  assign w_dark = r_act_blank[r_idx] | w_lzb_blank[r_idx] | w_blink_off;

  sseg_hex_decoder u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sseg <= SEG_OFF;
      r_an   <= '1;
    end else begin
      r_sseg <= w_dark ? SEG_OFF : w_seg;
      r_an   <= ~(N_DIG'(1) << r_idx);
    end
  end

  assign sseg       = r_sseg;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule
